// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/freeze sequencing with dmem timeout watchdog (optional HAZARD_PERF_CNT_EN stall counter)
module hazard_ctrl #(
  parameter int REG_AW      = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1ID,
  input  logic [REG_AW-1:0] rs2ID,
  input  logic              useRs1ID,
  input  logic              useRs2ID,
  input  logic              BranchID,
  input  logic              BranchTakenID,
  input  logic [REG_AW-1:0] rdEX,
  input  logic              RegWriteEX,
  input  logic              MemReadEX,
  input  logic [REG_AW-1:0] rdMEM,
  input  logic              MemReadMEM,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              IFIDFlush,
  output logic              IDEXFlush,
  output logic              PipeHold,
  output logic              MEMWBFlush,
  output logic              bus_err,
  output logic [CNT_W-1:0]  stall_cycles
);
  typedef enum logic [1:0] {RUN, STALL, MEM_WAIT, HALT} state_t;
  state_t state, resume;
  logic [1:0] cnt;
  logic [7:0] wcnt;
  logic hit_ex, hit_mem, n1, n2, mem_wait, freeze, stall;
  // hazard detection and Mealy output decode
  always_comb begin
    hit_ex   = rdEX != '0 && ((useRs1ID && rs1ID == rdEX) || (useRs2ID && rs2ID == rdEX));
    hit_mem  = rdMEM != '0 && ((useRs1ID && rs1ID == rdMEM) || (useRs2ID && rs2ID == rdMEM));
    n2       = BranchID && MemReadEX && hit_ex;
    n1       = (MemReadEX && hit_ex) || (BranchID && ((RegWriteEX && !MemReadEX && hit_ex) || (MemReadMEM && hit_mem)));
    mem_wait = dmem_req && !dmem_ready;
    freeze   = state == HALT || state == MEM_WAIT || ((state == RUN || state == STALL) && mem_wait);
    stall    = !freeze && (state == STALL || (state == RUN && (n1 || n2)));
    PCWrite    = !freeze && !stall;
    IFIDWrite  = !freeze && !stall;
    IFIDFlush  = state == RUN && !freeze && !stall && BranchID && BranchTakenID;
    IDEXFlush  = stall;
    PipeHold   = freeze;
    MEMWBFlush = freeze;
  end
  // sequencing FSM with stall and wait counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      resume  <= RUN;
      cnt     <= '0;
      wcnt    <= '0;
      bus_err <= 1'b0;
    end else if ((state == RUN || state == STALL) && mem_wait) begin
      if (MEM_TIMEOUT == 1) begin
        state   <= HALT;
        bus_err <= 1'b1;
      end else begin
        state  <= MEM_WAIT;
        resume <= state;
        wcnt   <= 8'd1;
      end
    end else begin
      case (state)
        RUN: if (n2) begin
          state <= STALL;
          cnt   <= 2'd1;
        end
        STALL: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= RUN;
        end
        MEM_WAIT: if (dmem_ready) state <= resume;
        else if (wcnt == 8'(MEM_TIMEOUT - 1)) begin
          state   <= HALT;
          bus_err <= 1'b1;
        end else wcnt <= wcnt + 8'd1;
        default: state <= HALT;
      endcase
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf;
  // saturating count of non-halted cycles with the PC held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf <= '0;
    else if (!PCWrite && state != HALT && perf != '1) perf <= perf + 1'b1;
  end
  assign stall_cycles = perf;
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl stall, branch, freeze, timeout and reset behaviour
module tb_hazard_ctrl;
  typedef struct packed {
    logic [2:0] rs1, rs2;
    logic u1, u2, br, bt;
    logic [2:0] rdex;
    logic rwex, mrex;
    logic [2:0] rdmem;
    logic mrmem, req, rdy;
  } stim_t;
  localparam logic [6:0] RUNO = 7'b1100000;
  localparam logic [6:0] STL  = 7'b0001000;
  localparam logic [6:0] BRF  = 7'b1110000;
  localparam logic [6:0] FRZ  = 7'b0000110;
  localparam logic [6:0] FRZE = 7'b0000111;
  logic clk = 0, rst_n = 0;
  stim_t s = '0;
  logic PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, PipeHold, MEMWBFlush, bus_err;
  logic [15:0] stall_cycles;
  logic [6:0] o, e;
  logic [6:0] sb[$];
  int checks = 0, failures = 0;
  assign o = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, PipeHold, MEMWBFlush, bus_err};
  always #5 clk = ~clk;
  hazard_ctrl #(.REG_AW(3), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rs1ID(s.rs1), .rs2ID(s.rs2), .useRs1ID(s.u1), .useRs2ID(s.u2),
    .BranchID(s.br), .BranchTakenID(s.bt), .rdEX(s.rdex), .RegWriteEX(s.rwex), .MemReadEX(s.mrex),
    .rdMEM(s.rdmem), .MemReadMEM(s.mrmem), .dmem_req(s.req), .dmem_ready(s.rdy),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .PipeHold(PipeHold), .MEMWBFlush(MEMWBFlush), .bus_err(bus_err), .stall_cycles(stall_cycles));

  function automatic stim_t mk(input logic [2:0] rs1, rs2, input logic u1, u2, br, bt,
                               input logic [2:0] rdex, input logic rwex, mrex,
                               input logic [2:0] rdmem, input logic mrmem, req, rdy);
    return '{rs1, rs2, u1, u2, br, bt, rdex, rwex, mrex, rdmem, mrmem, req, rdy};
  endfunction

  task automatic pulse_reset;
    s = '0;
    rst_n = 0;
    #2 rst_n = 1;
  endtask

  task automatic test_reset;
    s = '0;
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (o !== RUNO) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", o, RUNO); end
    checks++;
    if (stall_cycles !== 16'd0) begin failures++; $display("FAIL reset_counter got=%0d exp=0", stall_cycles); end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_load_use;
    stim_t sv[$];
    logic [6:0] ev[$];
    sv = '{mk(3,0,1,0,0,0,3,1,1,0,0,0,0), mk(3,0,1,0,0,0,0,0,0,3,1,0,0), mk(0,0,0,0,0,0,0,0,0,0,0,0,0),
           mk(0,3,0,1,0,0,3,1,1,0,0,0,0), mk(0,3,0,1,0,0,0,0,0,3,1,0,0)};
    ev = '{STL, RUNO, RUNO, STL, RUNO};
    for (int i = 0; i < sv.size(); i++) begin
      s = sv[i];
      sb.push_back(ev[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL load_use cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_no_hazard;
    stim_t sv[$];
    logic [6:0] ev[$];
    sv = '{mk(0,0,1,0,0,0,0,1,1,0,0,0,0), mk(3,0,0,0,0,0,3,1,1,0,0,0,0), mk(3,3,1,1,0,0,3,1,0,0,0,0,0),
           mk(3,0,1,0,0,0,0,0,0,3,1,0,0), mk(4,0,1,0,1,0,0,0,0,0,0,0,0), mk(4,0,1,0,0,0,5,1,1,0,0,1,1)};
    ev = '{RUNO, RUNO, RUNO, RUNO, RUNO, RUNO};
    for (int i = 0; i < sv.size(); i++) begin
      s = sv[i];
      sb.push_back(ev[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL no_hazard cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    stim_t sv[$];
    logic [6:0] ev[$];
    sv = '{mk(0,2,0,1,1,1,2,1,1,0,0,0,0), mk(0,2,0,1,1,1,0,0,0,2,1,0,0), mk(0,2,0,1,1,1,0,0,0,0,0,0,0),
           mk(1,0,1,0,1,1,1,1,0,0,0,0,0), mk(1,0,1,0,1,1,0,0,0,1,0,0,0),
           mk(0,6,0,1,1,0,0,0,0,6,1,0,0), mk(0,6,0,1,1,0,0,0,0,0,0,0,0),
           mk(4,5,1,1,1,0,5,1,1,4,1,0,0), mk(4,5,1,1,1,0,5,1,1,4,1,0,0), mk(4,5,1,1,1,1,0,0,0,0,0,0,0)};
    ev = '{STL, STL, BRF, STL, BRF, STL, RUNO, STL, STL, BRF};
    for (int i = 0; i < sv.size(); i++) begin
      s = sv[i];
      sb.push_back(ev[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL branch cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait_run;
    stim_t sv[$];
    logic [6:0] ev[$];
    sv = '{mk(3,0,1,0,0,0,3,1,1,0,0,1,0), mk(3,0,1,0,0,0,3,1,1,0,0,1,0), mk(3,0,1,0,0,0,3,1,1,0,0,1,1),
           mk(3,0,1,0,0,0,3,1,1,0,0,0,0), mk(0,0,0,0,0,0,0,0,0,0,0,0,0)};
    ev = '{FRZ, FRZ, FRZ, STL, RUNO};
    for (int i = 0; i < sv.size(); i++) begin
      s = sv[i];
      sb.push_back(ev[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL mem_wait_run cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait_stall;
    stim_t sv[$];
    logic [6:0] ev[$];
    stim_t b, w, r;
    logic [15:0] exp_cnt;
    b = mk(0,2,0,1,1,1,2,1,1,0,0,0,0);
    w = b; w.req = 1;
    r = w; r.rdy = 1;
    pulse_reset();
    @(posedge clk); #1;
    sv = '{b, w, w, w, w, r, b, mk(0,2,0,1,1,1,0,0,0,0,0,0,0)};
    ev = '{STL, FRZ, FRZ, FRZ, FRZ, FRZ, STL, BRF};
    for (int i = 0; i < sv.size(); i++) begin
      s = sv[i];
      sb.push_back(ev[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL mem_wait_stall cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
`ifdef HAZARD_PERF_CNT_EN
    exp_cnt = 16'd7;
`else
    exp_cnt = 16'd0;
`endif
    checks++;
    if (stall_cycles !== exp_cnt) begin failures++; $display("FAIL stall_cycles got=%0d exp=%0d", stall_cycles, exp_cnt); end
  endtask

  task automatic test_timeout;
    stim_t sv[$];
    logic [6:0] ev[$];
    pulse_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) begin
      sv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,0));
      ev.push_back(FRZ);
    end
    sv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,0));
    sv.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,1));
    sv.push_back(mk(3,0,1,0,0,0,3,1,1,0,0,0,0));
    sv.push_back(mk(0,0,0,0,1,1,0,0,0,0,0,0,0));
    repeat (4) ev.push_back(FRZE);
    for (int i = 0; i < sv.size(); i++) begin
      s = sv[i];
      sb.push_back(ev[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (o !== e) begin failures++; $display("FAIL timeout cyc=%0d got=%b exp=%b", i, o, e); end
      @(posedge clk); #1;
    end
    s = '0;
    rst_n = 0;
    #1;
    checks++;
    if (o !== RUNO) begin failures++; $display("FAIL halt_reset got=%b exp=%b", o, RUNO); end
    #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_stall;
    s = mk(0,2,0,1,1,1,2,1,1,0,0,0,0);
    @(negedge clk);
    checks++;
    if (o !== STL) begin failures++; $display("FAIL rst_stall_enter got=%b exp=%b", o, STL); end
    @(posedge clk); #1;
    s = '0;
    checks++;
    if (o !== STL) begin failures++; $display("FAIL rst_stall_mid got=%b exp=%b", o, STL); end
    #1 rst_n = 0;
    #1;
    checks++;
    if (o !== RUNO) begin failures++; $display("FAIL rst_stall_async got=%b exp=%b", o, RUNO); end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (o !== RUNO) begin failures++; $display("FAIL rst_stall_after got=%b exp=%b", o, RUNO); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (o !== RUNO) begin failures++; $display("FAIL rst_stall_next got=%b exp=%b", o, RUNO); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_mem_wait_run();
    test_mem_wait_stall();
    test_timeout();
    test_reset_in_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
